// File: rtl/bucket_hash_table_if.sv
// Build, probe and result channels of the bucket hash join table.
interface bucket_hash_table_if #(
  parameter int unsigned TUPLE_W  = 64,
  parameter int unsigned SERIAL_W = 64
);
  // build side
  logic                  build_valid;
  logic                  build_ready;
  logic [TUPLE_W-1:0]    build_data;
  logic [31:0]           build_hash;
  logic                  build_last;
  // probe side
  logic                  probe_valid;
  logic                  probe_ready;
  logic [TUPLE_W-1:0]    probe_data;
  logic [31:0]           probe_hash;
  logic [SERIAL_W-1:0]   probe_serial;
  logic                  probe_last;
  // join results
  logic                  out_valid;
  logic                  out_ready;
  logic [2*TUPLE_W-1:0]  out_data;
  logic [SERIAL_W-1:0]   out_serial;
  logic                  out_joined;
  logic                  out_last;
  // status
  logic                  overflow;
  logic [31:0]           build_count;

  // driver of build/probe streams and sink of results
  modport master (
    output build_valid, build_data, build_hash, build_last,
    input  build_ready,
    output probe_valid, probe_data, probe_hash, probe_serial, probe_last,
    input  probe_ready,
    input  out_valid, out_data, out_serial, out_joined, out_last,
    output out_ready,
    input  overflow, build_count
  );

  // the hash table itself
  modport slave (
    input  build_valid, build_data, build_hash, build_last,
    output build_ready,
    input  probe_valid, probe_data, probe_hash, probe_serial, probe_last,
    output probe_ready,
    output out_valid, out_data, out_serial, out_joined, out_last,
    input  out_ready,
    output overflow, build_count
  );
endinterface

// File: rtl/bucket_hash_table.sv
// Bucketed hash join: stores build tuples per bucket, then scans the bucket
// for each probe tuple and emits one beat per key match (or one miss beat).
module bucket_hash_table #(
  parameter int unsigned TUPLE_W  = 64,
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SERIAL_W = 64
) (
  input  logic          clk,
  input  logic          resetn,
  bucket_hash_table_if.slave bus
);

  localparam int unsigned NUM_ROWS = 2 ** ROW_BITS;
  localparam int unsigned CNT_W    = $clog2(SLOTS + 1);
  localparam int unsigned JW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(SLOTS);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NUM_ROWS - 1);

  typedef struct packed {
    logic [CNT_W-1:0]              cnt;
    logic [SLOTS-1:0][TUPLE_W-1:0] slots;
  } row_t;

  typedef enum logic [2:0] {
    INIT, BUILD_RD, BUILD_WR, PROBE_RD, PROBE_SCAN, DONE
  } state_t;

  state_t               state_q;
  logic [ROW_BITS-1:0]  init_addr_q;
  logic [ROW_BITS-1:0]  bidx_q;
  logic [TUPLE_W-1:0]   b_tuple_q;
  logic                 b_last_q;
  logic [TUPLE_W-1:0]   p_tuple_q;
  logic [SERIAL_W-1:0]  p_serial_q;
  logic                 p_last_q;
  logic [JW-1:0]        j_q;
  row_t                 rd_row_q;
  row_t                 mem_q [NUM_ROWS];

  logic                 out_valid_q;
  logic [2*TUPLE_W-1:0] out_data_q;
  logic [SERIAL_W-1:0]  out_serial_q;
  logic                 out_joined_q;
  logic                 out_last_q;
  logic                 overflow_q;
  logic [31:0]          build_count_q;

  logic                 can_load;
  logic                 probe_fire;
  logic [SLOTS-1:0]     match_vec;
  logic                 cur_match;
  logic [TUPLE_W-1:0]   cur_tuple;
  logic                 later_match;
  logic                 scan_last_slot;
  row_t                 row_wr_d;
  logic                 mem_we;
  logic                 mem_re;
  logic [ROW_BITS-1:0]  mem_waddr;
  logic [ROW_BITS-1:0]  mem_raddr;
  row_t                 mem_wdata;
  logic                 unused_hash_bits;

  assign unused_hash_bits = ^{bus.build_hash[31:ROW_BITS], bus.probe_hash[31:ROW_BITS]};

  // output register may take a new beat when empty or being drained
  assign can_load        = !out_valid_q || bus.out_ready;
  assign probe_fire      = (state_q == PROBE_RD) && bus.probe_valid && can_load;
  assign bus.build_ready = (state_q == BUILD_RD);
  assign bus.probe_ready = (state_q == PROBE_RD) && can_load;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_serial  = out_serial_q;
  assign bus.out_joined  = out_joined_q;
  assign bus.out_last    = out_last_q;
  assign bus.overflow    = overflow_q;
  assign bus.build_count = build_count_q;

  // key compare of every occupied slot against the captured probe tuple
  always_comb begin
    match_vec   = '0;
    cur_match   = 1'b0;
    cur_tuple   = '0;
    later_match = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      match_vec[s] = (CNT_W'(s) < rd_row_q.cnt) &&
                     (rd_row_q.slots[s][KEY_W-1:0] == p_tuple_q[KEY_W-1:0]);
    end
    for (int s = 0; s < SLOTS; s++) begin
      if (JW'(s) == j_q) begin
        cur_match = match_vec[s];
        cur_tuple = rd_row_q.slots[s];
      end
      if (JW'(s) > j_q) later_match = later_match | match_vec[s];
    end
    scan_last_slot = (rd_row_q.cnt == '0) ||
                     ((CNT_W'(j_q) + CNT_W'(1)) == rd_row_q.cnt);
  end

  // bucket with the captured build tuple appended
  always_comb begin
    row_wr_d = rd_row_q;
    for (int s = 0; s < SLOTS; s++) begin
      if (CNT_W'(s) == rd_row_q.cnt) row_wr_d.slots[s] = b_tuple_q;
    end
    row_wr_d.cnt = rd_row_q.cnt + CNT_W'(1);
  end

  // table RAM port control
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = init_addr_q;
    mem_wdata = '0;
    mem_raddr = bus.build_hash[ROW_BITS-1:0];
    case (state_q)
      INIT:     mem_we = 1'b1;
      BUILD_RD: mem_re = bus.build_valid;
      BUILD_WR: begin
        mem_we    = (rd_row_q.cnt != FULL_CNT);
        mem_waddr = bidx_q;
        mem_wdata = row_wr_d;
      end
      PROBE_RD: begin
        mem_re    = probe_fire;
        mem_raddr = bus.probe_hash[ROW_BITS-1:0];
      end
      default: ;
    endcase
  end

  // one-read-one-write table storage, 1-cycle read latency
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (mem_re) rd_row_q <= mem_q[mem_raddr];
  end

  // control FSM with registered result beat and status
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= INIT;
      init_addr_q   <= '0;
      bidx_q        <= '0;
      b_tuple_q     <= '0;
      b_last_q      <= 1'b0;
      p_tuple_q     <= '0;
      p_serial_q    <= '0;
      p_last_q      <= 1'b0;
      j_q           <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_serial_q  <= '0;
      out_joined_q  <= 1'b0;
      out_last_q    <= 1'b0;
      overflow_q    <= 1'b0;
      build_count_q <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        INIT: begin
          init_addr_q <= init_addr_q + ROW_BITS'(1);
          if (init_addr_q == LAST_ROW) state_q <= BUILD_RD;
        end
        BUILD_RD: begin
          if (bus.build_valid) begin
            b_tuple_q <= bus.build_data;
            b_last_q  <= bus.build_last;
            bidx_q    <= bus.build_hash[ROW_BITS-1:0];
            state_q   <= BUILD_WR;
          end else if (bus.build_last) begin
            state_q <= PROBE_RD;
          end
        end
        BUILD_WR: begin
          if (rd_row_q.cnt != FULL_CNT) build_count_q <= build_count_q + 32'd1;
          else                          overflow_q    <= 1'b1;
          state_q <= b_last_q ? PROBE_RD : BUILD_RD;
        end
        PROBE_RD: begin
          if (can_load) begin
            if (bus.probe_valid) begin
              p_tuple_q  <= bus.probe_data;
              p_serial_q <= bus.probe_serial;
              p_last_q   <= bus.probe_last;
              j_q        <= '0;
              state_q    <= PROBE_SCAN;
            end else if (bus.probe_last) begin
              out_valid_q  <= 1'b1;
              out_data_q   <= '0;
              out_serial_q <= '0;
              out_joined_q <= 1'b0;
              out_last_q   <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        PROBE_SCAN: begin
          if (can_load) begin
            if (cur_match) begin
              out_valid_q  <= 1'b1;
              out_data_q   <= {cur_tuple, p_tuple_q};
              out_serial_q <= p_serial_q;
              out_joined_q <= 1'b1;
              out_last_q   <= p_last_q && !later_match;
            end else if (scan_last_slot && (match_vec == '0)) begin
              out_valid_q  <= 1'b1;
              out_data_q   <= {{TUPLE_W{1'b0}}, p_tuple_q};
              out_serial_q <= p_serial_q;
              out_joined_q <= 1'b0;
              out_last_q   <= p_last_q;
            end
            if (scan_last_slot) state_q <= p_last_q ? DONE : PROBE_RD;
            else                j_q     <= j_q + JW'(1);
          end
        end
        DONE: ;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bucket_hash_table.sv
// Directed self-checking bench for bucket_hash_table.
module tb_bucket_hash_table;

  localparam int unsigned TUPLE_W  = 64;
  localparam int unsigned KEY_W    = 32;
  localparam int unsigned ROW_BITS = 3;
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned SERIAL_W = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bucket_hash_table_if #(.TUPLE_W(TUPLE_W), .SERIAL_W(SERIAL_W)) bus ();

  bucket_hash_table #(
    .TUPLE_W(TUPLE_W), .KEY_W(KEY_W), .ROW_BITS(ROW_BITS),
    .SLOTS(SLOTS), .SERIAL_W(SERIAL_W)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2*TUPLE_W-1:0] data;
    logic [SERIAL_W-1:0]  serial;
    logic                 joined;
    logic                 last;
    int                   cyc;
  } beat_t;

  beat_t beats[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t get_beat(input int i);
    beat_t b;
    b.data = '0; b.serial = '0; b.joined = 1'b0; b.last = 1'b0; b.cyc = -1;
    if (i < beats.size()) b = beats[i];
    return b;
  endfunction

  task automatic check_beat(input string tag, input int i, input logic [127:0] data,
                            input logic [63:0] serial, input logic joined,
                            input logic last, input int cyc);
    beat_t b;
    b = get_beat(i);
    check({tag, "_data"},   b.data, data);
    check({tag, "_serial"}, 128'(b.serial), 128'(serial));
    check({tag, "_joined"}, 128'(b.joined), 128'(joined));
    check({tag, "_last"},   128'(b.last), 128'(last));
    if (cyc >= 0) check({tag, "_cycle"}, 128'(b.cyc), 128'(cyc));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"},   128'(bus.out_valid), 128'd0);
    check({tag, "_out_data"},    128'(bus.out_data), 128'd0);
    check({tag, "_out_serial"},  128'(bus.out_serial), 128'd0);
    check({tag, "_out_joined"},  128'(bus.out_joined), 128'd0);
    check({tag, "_out_last"},    128'(bus.out_last), 128'd0);
    check({tag, "_overflow"},    128'(bus.overflow), 128'd0);
    check({tag, "_build_count"}, 128'(bus.build_count), 128'd0);
    check({tag, "_build_ready"}, 128'(bus.build_ready), 128'd0);
    check({tag, "_probe_ready"}, 128'(bus.probe_ready), 128'd0);
  endtask

  task automatic wait_build_ready();
    int n = 0;
    while (bus.build_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("build_ready_wait", 128'(bus.build_ready), 128'd1);
  endtask

  task automatic wait_probe_ready();
    int n = 0;
    while (bus.probe_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("probe_ready_wait", 128'(bus.probe_ready), 128'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.build_valid = 1'b0; bus.build_last = 1'b0;
    bus.probe_valid = 1'b0; bus.probe_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic build_push(input logic [63:0] d, input logic [31:0] h, input logic l);
    @(negedge clk);
    bus.build_valid = 1'b1; bus.build_data = d; bus.build_hash = h; bus.build_last = l;
    wait_build_ready();
    @(posedge clk); #1;
    bus.build_valid = 1'b0; bus.build_last = 1'b0;
  endtask

  task automatic build_end();
    @(negedge clk);
    wait_build_ready();
    bus.build_last = 1'b1;
    @(posedge clk); #1;
    bus.build_last = 1'b0;
  endtask

  task automatic probe_send(input logic [63:0] d, input logic [31:0] h,
                            input logic [63:0] s, input logic l);
    @(negedge clk);
    bus.probe_valid = 1'b1; bus.probe_data = d; bus.probe_hash = h;
    bus.probe_serial = s; bus.probe_last = l;
    wait_probe_ready();
    @(posedge clk); #1;
    bus.probe_valid = 1'b0; bus.probe_last = 1'b0;
  endtask

  // sample result beats for ncyc cycles after the probe handshake edge
  task automatic collect(input int ncyc, input int stall_from, input int stall_to);
    beat_t b;
    beats.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= stall_from && c < stall_to);
      if (bus.out_valid && bus.out_ready) begin
        b.data = bus.out_data; b.serial = bus.out_serial;
        b.joined = bus.out_joined; b.last = bus.out_last; b.cyc = c;
        beats.push_back(b);
      end
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_ready;
    bus.build_valid = 1'b0; bus.build_data = '0; bus.build_hash = '0; bus.build_last = 1'b0;
    bus.probe_valid = 1'b0; bus.probe_data = '0; bus.probe_hash = '0;
    bus.probe_serial = '0; bus.probe_last = 1'b0;
    bus.out_ready = 1'b1;

    // reset values and the table clear sweep
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    resetn = 1'b1;
    any_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any_ready = any_ready | bus.build_ready | bus.probe_ready;
      @(negedge clk);
    end
    check("init_readies_low", 128'(any_ready), 128'd0);
    check("init_build_ready_cycle9", 128'(bus.build_ready), 128'd1);

    // two keys in bucket 2, match in slot 1
    build_push(64'd5, 32'd2, 1'b0);
    build_push(64'd6, 32'd2, 1'b0);
    build_push(64'd100, 32'd5, 1'b1);
    wait_probe_ready();
    check("s1_build_count", 128'(bus.build_count), 128'd3);
    check("s1_overflow", 128'(bus.overflow), 128'd0);
    probe_send(64'd6, 32'd2, 64'd7, 1'b0);
    collect(6, 99, 99);
    check("s1_nbeats", 128'(beats.size()), 128'd1);
    check_beat("s1_hit", 0, {64'd6, 64'd6}, 64'd7, 1'b1, 1'b0, 2);
    probe_send(64'd100, 32'd13, 64'd8, 1'b1);
    collect(5, 99, 99);
    check("s1b_nbeats", 128'(beats.size()), 128'd1);
    check_beat("s1b_hit_last", 0, {64'd100, 64'd100}, 64'd8, 1'b1, 1'b1, 1);
    check("s1_done_build_ready", 128'(bus.build_ready), 128'd0);
    check("s1_done_probe_ready", 128'(bus.probe_ready), 128'd0);
    check("s1_done_out_valid", 128'(bus.out_valid), 128'd0);

    // three matches in one bucket with a mid-stream stall
    do_reset();
    wait_build_ready();
    build_push({32'hA0, 32'd9}, 32'd1, 1'b0);
    build_push({32'hA1, 32'd9}, 32'd1, 1'b0);
    build_push({32'hA2, 32'd9}, 32'd1, 1'b0);
    build_end();
    wait_probe_ready();
    check("s2_build_count", 128'(bus.build_count), 128'd3);
    probe_send(64'd9, 32'd1, 64'd42, 1'b1);
    collect(14, 2, 6);
    check("s2_nbeats", 128'(beats.size()), 128'd3);
    check_beat("s2_b0", 0, {32'hA0, 32'd9, 64'd9}, 64'd42, 1'b1, 1'b0, 1);
    check_beat("s2_b1", 1, {32'hA1, 32'd9, 64'd9}, 64'd42, 1'b1, 1'b0, 6);
    check_beat("s2_b2", 2, {32'hA2, 32'd9, 64'd9}, 64'd42, 1'b1, 1'b1, 7);
    check("s2_done_probe_ready", 128'(bus.probe_ready), 128'd0);

    // bucket overflow, miss on the dropped key, hit in an early slot as final beat
    do_reset();
    wait_build_ready();
    for (int k = 11; k <= 15; k++) build_push(64'(k), 32'd0, (k == 15));
    wait_probe_ready();
    check("s3_overflow", 128'(bus.overflow), 128'd1);
    check("s3_build_count", 128'(bus.build_count), 128'd4);
    probe_send(64'd15, 32'd8, 64'd99, 1'b0);
    collect(8, 99, 99);
    check("s3_nbeats", 128'(beats.size()), 128'd1);
    check_beat("s3_miss", 0, {64'd0, 64'd15}, 64'd99, 1'b0, 1'b0, 4);
    probe_send(64'd12, 32'd0, 64'd100, 1'b1);
    collect(8, 99, 99);
    check("s3b_nbeats", 128'(beats.size()), 128'd1);
    check_beat("s3b_hit_last", 0, {64'd12, 64'd12}, 64'd100, 1'b1, 1'b1, 2);

    // empty build, probe of an empty bucket with last set
    do_reset();
    wait_build_ready();
    build_end();
    probe_send(64'd3, 32'd3, 64'd5, 1'b1);
    collect(5, 99, 99);
    check("s4_nbeats", 128'(beats.size()), 128'd1);
    check_beat("s4_miss_last", 0, {64'd0, 64'd3}, 64'd5, 1'b0, 1'b1, 1);
    check("s4_done_build_ready", 128'(bus.build_ready), 128'd0);
    check("s4_done_probe_ready", 128'(bus.probe_ready), 128'd0);

    // end of probe stream without a tuple
    do_reset();
    wait_build_ready();
    build_end();
    @(negedge clk);
    check("s5_probe_ready", 128'(bus.probe_ready), 128'd1);
    bus.probe_last = 1'b1;
    @(posedge clk); #1;
    bus.probe_last = 1'b0;
    @(negedge clk);
    check("s5_out_valid", 128'(bus.out_valid), 128'd1);
    check("s5_out_data", bus.out_data, 128'd0);
    check("s5_out_serial", 128'(bus.out_serial), 128'd0);
    check("s5_out_joined", 128'(bus.out_joined), 128'd0);
    check("s5_out_last", 128'(bus.out_last), 128'd1);
    @(negedge clk);
    check("s5_drained", 128'(bus.out_valid), 128'd0);
    check("s5_done_probe_ready", 128'(bus.probe_ready), 128'd0);

    // reset while a beat is stalled mid-scan, then re-probe the cleared table
    do_reset();
    wait_build_ready();
    build_push(64'd7, 32'd4, 1'b0);
    build_push(64'd7, 32'd4, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    probe_send(64'd7, 32'd4, 64'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("s6_stalled_valid", 128'(bus.out_valid), 128'd1);
    check("s6_stalled_data", bus.out_data, {64'd7, 64'd7});
    resetn = 1'b0;
    @(negedge clk);
    check_idle("s6_after_reset");
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    wait_build_ready();
    build_end();
    probe_send(64'd7, 32'd4, 64'd4, 1'b1);
    collect(5, 99, 99);
    check("s6_nbeats", 128'(beats.size()), 128'd1);
    check_beat("s6_reprobe_miss", 0, {64'd0, 64'd7}, 64'd4, 1'b0, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
